// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back commit controller.
package wb_pkg;

    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [31:0] MCAUSE_ECALL = 32'd11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        TRAP   = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dnpc;
        logic        gpr_wen;
        logic [4:0]  rd;
        logic [31:0] gpr_wdata;
        logic        csr_wen;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
        logic        is_ecall;
        logic        is_mret;
    } wb_pkt_t;

endpackage

// File: rtl/wb_retire_counter.sv
// 64-bit retired-instruction counter; wraps silently.
module wb_retire_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_en) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 64'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wb_commit_ctrl.sv
// Write-back commit sequencer: captures one packet per handshake, drives GPR/CSR
// write ports, owns the architectural PC and expands ecall into mepc/mcause writes.
module wb_commit_ctrl
    import wb_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [31:0] pc_in,
    input  logic [31:0] dnpc_in,
    input  logic        gpr_wen_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] gpr_wdata_in,
    input  logic        csr_wen_in,
    input  logic [11:0] csr_waddr_in,
    input  logic [31:0] csr_wdata_in,
    input  logic        is_ecall_in,
    input  logic        is_mret_in,
    output logic        gpr_we,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [31:0] pc,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic        trap_flush,
    output logic [63:0] minstret
);

    wb_state_e   state_q, state_d;
    wb_pkt_t     pkt_q, pkt_d;
    logic [31:0] pc_q;
    logic        transfer;
    logic        retire;

    assign pkt_d = '{
        pc:        pc_in,
        dnpc:      dnpc_in,
        gpr_wen:   gpr_wen_in,
        rd:        rd_in,
        gpr_wdata: gpr_wdata_in,
        csr_wen:   csr_wen_in,
        csr_waddr: csr_waddr_in,
        csr_wdata: csr_wdata_in,
        is_ecall:  is_ecall_in,
        is_mret:   is_mret_in
    };

    // mret needs no special handling here: the WBU already folded mepc into dnpc.
    logic unused_mret;
    assign unused_mret = pkt_q.is_mret;

    assign ready_out = (state_q == IDLE) || ((state_q == COMMIT) && !pkt_q.is_ecall);
    assign transfer  = valid_in && ready_out;
    assign retire    = ((state_q == COMMIT) && !pkt_q.is_ecall) || (state_q == TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:    state_d = transfer ? COMMIT : IDLE;
            COMMIT:  state_d = pkt_q.is_ecall ? TRAP : (transfer ? COMMIT : IDLE);
            TRAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gpr_we       = 1'b0;
        gpr_waddr    = 5'd0;
        gpr_wdata    = 32'd0;
        csr_we       = 1'b0;
        csr_waddr    = 12'd0;
        csr_wdata    = 32'd0;
        commit_valid = 1'b0;
        commit_pc    = 32'd0;
        trap_flush   = 1'b0;
        unique case (state_q)
            COMMIT: begin
                if (pkt_q.is_ecall) begin
                    csr_we    = 1'b1;
                    csr_waddr = CSR_MEPC;
                    csr_wdata = pkt_q.pc;
                end else begin
                    gpr_we       = pkt_q.gpr_wen && (pkt_q.rd != 5'd0);
                    gpr_waddr    = pkt_q.rd;
                    gpr_wdata    = pkt_q.gpr_wdata;
                    csr_we       = pkt_q.csr_wen;
                    csr_waddr    = pkt_q.csr_waddr;
                    csr_wdata    = pkt_q.csr_wdata;
                    commit_valid = 1'b1;
                    commit_pc    = pkt_q.pc;
                end
            end
            TRAP: begin
                csr_we       = 1'b1;
                csr_waddr    = CSR_MCAUSE;
                csr_wdata    = MCAUSE_ECALL;
                commit_valid = 1'b1;
                commit_pc    = pkt_q.pc;
                trap_flush   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
            pc_q  <= RESET_PC;
        end else begin
            if (transfer) begin
                pkt_q <= pkt_d;
            end
            if (retire) begin
                pc_q <= pkt_q.dnpc;
            end
        end
    end

    assign pc = pc_q;

    wb_retire_counter u_retire_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (retire),
        .count  (minstret)
    );

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Directed self-checking bench for wb_commit_ctrl.
module tb_wb_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] pc_in, dnpc_in, gpr_wdata_in, csr_wdata_in;
    logic        gpr_wen_in, csr_wen_in, is_ecall_in, is_mret_in;
    logic [4:0]  rd_in;
    logic [11:0] csr_waddr_in;
    logic        gpr_we, csr_we, commit_valid, trap_flush;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata, csr_wdata, pc, commit_pc;
    logic [11:0] csr_waddr;
    logic [63:0] minstret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_commit_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .pc_in        (pc_in),
        .dnpc_in      (dnpc_in),
        .gpr_wen_in   (gpr_wen_in),
        .rd_in        (rd_in),
        .gpr_wdata_in (gpr_wdata_in),
        .csr_wen_in   (csr_wen_in),
        .csr_waddr_in (csr_waddr_in),
        .csr_wdata_in (csr_wdata_in),
        .is_ecall_in  (is_ecall_in),
        .is_mret_in   (is_mret_in),
        .gpr_we       (gpr_we),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata),
        .csr_we       (csr_we),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .pc           (pc),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .trap_flush   (trap_flush),
        .minstret     (minstret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] dn, input logic gw,
                         input logic [4:0] rd, input logic [31:0] gd, input logic cw,
                         input logic [11:0] ca, input logic [31:0] cd, input logic ec,
                         input logic mr);
        valid_in     = 1'b1;
        pc_in        = p;
        dnpc_in      = dn;
        gpr_wen_in   = gw;
        rd_in        = rd;
        gpr_wdata_in = gd;
        csr_wen_in   = cw;
        csr_waddr_in = ca;
        csr_wdata_in = cd;
        is_ecall_in  = ec;
        is_mret_in   = mr;
    endtask

    logic [31:0] s_pc [4] = '{32'h8000_0004, 32'h8000_0008, 32'h8000_000C, 32'h8000_0010};
    logic [4:0]  s_rd [4] = '{5'd1, 5'd2, 5'd0, 5'd4};
    logic [31:0] s_wd [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        rst_n = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
        valid_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_minstret", minstret, 64'd0);
        check("rst_gpr_we", gpr_we, 1'b0);
        check("rst_csr_we", csr_we, 1'b0);
        check("rst_commit", commit_valid, 1'b0);
        check("rst_flush", trap_flush, 1'b0);
        check("rst_ready", ready_out, 1'b1);
        check("rst_commit_pc", commit_pc, 32'h0);

        // single addi x5 = 0x2A
        drive(32'h8000_0000, 32'h8000_0004, 1'b1, 5'd5, 32'h2A, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
        tick();
        valid_in = 1'b0;
        check("addi_gpr_we", gpr_we, 1'b1);
        check("addi_waddr", gpr_waddr, 5'd5);
        check("addi_wdata", gpr_wdata, 32'h2A);
        check("addi_commit", commit_valid, 1'b1);
        check("addi_commit_pc", commit_pc, 32'h8000_0000);
        check("addi_csr_we", csr_we, 1'b0);
        check("addi_pc_before", pc, 32'h8000_0000);
        tick();
        check("addi_pc_after", pc, 32'h8000_0004);
        check("addi_minstret", minstret, 64'd1);
        check("addi_idle_commit", commit_valid, 1'b0);

        // back-to-back stream, third packet targets x0
        for (int i = 0; i < 4; i++) begin
            drive(s_pc[i], s_pc[i] + 32'd4, 1'b1, s_rd[i], s_wd[i], 1'b0, 12'h0, 32'h0,
                  1'b0, 1'b0);
            check("b2b_ready", ready_out, 1'b1);
            tick();
            check("b2b_commit", commit_valid, 1'b1);
            check("b2b_commit_pc", commit_pc, s_pc[i]);
            check("b2b_gpr_we", gpr_we, (i == 2) ? 1'b0 : 1'b1);
            check("b2b_wdata", gpr_wdata, s_wd[i]);
        end
        valid_in = 1'b0;
        tick();
        check("b2b_minstret", minstret, 64'd5);
        check("b2b_pc", pc, 32'h8000_0014);
        check("b2b_idle", commit_valid, 1'b0);

        // csrrw x3, 0x305, with GPR and CSR writes in one cycle
        drive(32'h8000_0014, 32'h8000_0018, 1'b1, 5'd3, 32'h1234, 1'b1, 12'h305,
              32'h8000_1000, 1'b0, 1'b0);
        tick();
        valid_in = 1'b0;
        check("csrrw_gpr_we", gpr_we, 1'b1);
        check("csrrw_waddr", gpr_waddr, 5'd3);
        check("csrrw_gdata", gpr_wdata, 32'h1234);
        check("csrrw_csr_we", csr_we, 1'b1);
        check("csrrw_caddr", csr_waddr, 12'h305);
        check("csrrw_cdata", csr_wdata, 32'h8000_1000);
        tick();
        check("csrrw_minstret", minstret, 64'd6);

        // ecall with mret and csr_wen also set: both must be ignored
        drive(32'h8000_0010, 32'h8000_2000, 1'b0, 5'd0, 32'h0, 1'b1, 12'h300,
              32'hDEAD_BEEF, 1'b1, 1'b1);
        tick();
        drive(32'h8000_2000, 32'h8000_2004, 1'b1, 5'd7, 32'h77, 1'b0, 12'h0, 32'h0,
              1'b0, 1'b0);
        check("ecall1_csr_we", csr_we, 1'b1);
        check("ecall1_caddr", csr_waddr, 12'h341);
        check("ecall1_cdata", csr_wdata, 32'h8000_0010);
        check("ecall1_ready", ready_out, 1'b0);
        check("ecall1_commit", commit_valid, 1'b0);
        check("ecall1_gpr_we", gpr_we, 1'b0);
        check("ecall1_flush", trap_flush, 1'b0);
        tick();
        check("ecall2_csr_we", csr_we, 1'b1);
        check("ecall2_caddr", csr_waddr, 12'h342);
        check("ecall2_cdata", csr_wdata, 32'd11);
        check("ecall2_flush", trap_flush, 1'b1);
        check("ecall2_commit", commit_valid, 1'b1);
        check("ecall2_commit_pc", commit_pc, 32'h8000_0010);
        check("ecall2_ready", ready_out, 1'b0);
        tick();
        check("ecall_pc", pc, 32'h8000_2000);
        check("ecall_minstret", minstret, 64'd7);
        check("ecall_idle_ready", ready_out, 1'b1);
        check("ecall_idle_commit", commit_valid, 1'b0);
        tick();
        valid_in = 1'b0;
        check("queued_gpr_we", gpr_we, 1'b1);
        check("queued_waddr", gpr_waddr, 5'd7);
        check("queued_commit_pc", commit_pc, 32'h8000_2000);
        tick();
        check("queued_pc", pc, 32'h8000_2004);
        check("queued_minstret", minstret, 64'd8);

        // async reset during the TRAP cycle
        drive(32'h8000_2004, 32'h8000_2000, 1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0,
              1'b1, 1'b0);
        tick();
        valid_in = 1'b0;
        tick();
        check("rtrap_flush_pre", trap_flush, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rtrap_csr_we", csr_we, 1'b0);
        check("rtrap_flush", trap_flush, 1'b0);
        check("rtrap_commit", commit_valid, 1'b0);
        check("rtrap_pc", pc, 32'h8000_0000);
        check("rtrap_minstret", minstret, 64'd0);
        tick();
        check("rtrap_hold_csr_we", csr_we, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rtrap_post_csr_we", csr_we, 1'b0);
            check("rtrap_post_commit", commit_valid, 1'b0);
        end
        check("rtrap_ready", ready_out, 1'b1);
        check("rtrap_pc_hold", pc, 32'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
